// File: rtl/gen_freq_multi.sv
// -----------------------------------------------------------------------------
// gen_freq_multi
//
// Multi-channel programmable frequency divider. Each channel divides clk by its
// own runtime divider and drives a waveform (50% square or one-cycle pulse) plus
// a one-cycle tick usable as a clock enable. A new divider value is adopted only
// at a period boundary (or while the channel is held idle), so a running period
// is never shortened or stretched.
//
// Parameters:
//   WIDTH     bit width of each divider / counter
//   CHANNELS  number of independent channels
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (all channels)
//   en        per-channel enable
//   mode      per-channel waveform mode: 0 = square, 1 = pulse
//   divider   packed dividers, channel i at [i*WIDTH +: WIDTH]; 0 behaves as 1
//   sync      global phase realign; restarts every channel at once
//   wave_out  per-channel waveform (registered)
//   tick      per-channel terminal-count strobe (registered)
// -----------------------------------------------------------------------------
module gen_freq_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] divider,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       wave_out,
  output logic [CHANNELS-1:0]       tick
);

  logic [WIDTH-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    div_q    [CHANNELS];
  logic [WIDTH-1:0]    last_cnt [CHANNELS];
  logic [CHANNELS-1:0] at_term;
  logic [CHANNELS-1:0] wave_q;
  logic [CHANNELS-1:0] tick_q;

  // Terminal count is D-1 with D clamped to at least 1. Clamping before the
  // subtraction keeps a zero divider from wrapping to all-ones.
  // NOTE: every output of a combinational block gets a value on every path;
  // assigning defaults up front is what keeps synthesis from inferring latches.
  always_comb begin
    at_term = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      last_cnt[i] = (div_q[i] == '0) ? '0 : div_q[i] - WIDTH'(1);
      at_term[i]  = (cnt[i] == last_cnt[i]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; blocking assignments here would create order-dependent
  // simulation behaviour that no longer matches the synthesized flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst || sync || !en[i]) begin
        // Reset, realign and idle all park the channel at the start of a
        // period with the current divider captured.
        // NOTE: the shadow divider is loaded from the input on reset instead of
        // a constant, so the first period after reset uses the requested value.
        cnt[i]    <= '0;
        wave_q[i] <= 1'b0;
        tick_q[i] <= 1'b0;
        div_q[i]  <= divider[i*WIDTH +: WIDTH];
      end else if (at_term[i]) begin
        cnt[i]    <= '0;
        tick_q[i] <= 1'b1;
        div_q[i]  <= divider[i*WIDTH +: WIDTH];
        wave_q[i] <= mode[i] ? 1'b1 : ~wave_q[i];
      end else begin
        cnt[i]    <= cnt[i] + WIDTH'(1);
        tick_q[i] <= 1'b0;
        if (mode[i]) begin
          wave_q[i] <= 1'b0;
        end
      end
    end
  end

  assign wave_out = wave_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_gen_freq_multi.sv
// -----------------------------------------------------------------------------
// Testbench for gen_freq_multi. Directed scenarios followed by random traffic;
// a countdown-based reference model predicts each cycle's outputs into a
// scoreboard queue and a separate monitor compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_gen_freq_multi;

  localparam int W  = 32;
  localparam int CH = 4;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] divider;
  logic            sync;
  logic [CH-1:0]   wave_out;
  logic [CH-1:0]   tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gen_freq_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .divider  (divider),
    .sync     (sync),
    .wave_out (wave_out),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard entry: {wave, tick} predicted for the cycle after an edge.
  typedef struct {
    logic [CH-1:0] wave;
    logic [CH-1:0] tick;
    int            cycle;
  } exp_t;

  exp_t exp_q[$];
  bit   model_started = 0;

  task automatic check(input string name, input logic [2*CH-1:0] actual,
                       input logic [2*CH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got wave/tick=%b expected %b", name, actual, expected);
    end
  endtask

  // Reference model: each channel counts down the enabled edges remaining in
  // its current period. When the countdown expires a tick is emitted and a new
  // period of the then-current divider begins.
  initial begin : model
    longint        left [CH];
    logic [W-1:0]  pdiv [CH];
    logic [CH-1:0] lvl;
    logic [CH-1:0] tk;
    exp_t          e;
    lvl = '0;
    tk  = '0;
    forever begin
      @(posedge clk);
      if (rst) model_started = 1;
      if (model_started) begin
        for (int i = 0; i < CH; i++) begin
          if (rst || sync || !en[i]) begin
            pdiv[i] = divider[i*W +: W];
            left[i] = (pdiv[i] == 0) ? 1 : longint'(pdiv[i]);
            lvl[i]  = 1'b0;
            tk[i]   = 1'b0;
          end else begin
            left[i]--;
            if (left[i] == 0) begin
              tk[i]   = 1'b1;
              pdiv[i] = divider[i*W +: W];
              left[i] = (pdiv[i] == 0) ? 1 : longint'(pdiv[i]);
              lvl[i]  = mode[i] ? 1'b1 : ~lvl[i];
            end else begin
              tk[i] = 1'b0;
              if (mode[i]) lvl[i] = 1'b0;
            end
          end
        end
        e.wave  = lvl;
        e.tick  = tk;
        e.cycle = cyc;
        exp_q.push_back(e);
      end
      cyc++;
    end
  end

  // Monitor: samples the DUT just after each edge and retires one prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d", e.cycle), {wave_out, tick}, {e.wave, e.tick});
      end else if (model_started) begin
        check("scoreboard_underflow", 8'h01, 8'h00);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic e, input logic m,
                        input logic [W-1:0] d);
    en[i]           = e;
    mode[i]         = m;
    divider[i*W +: W] = d;
  endtask

  initial begin : stimulus
    int ch;
    rst     = 1'b1;
    sync    = 1'b0;
    en      = '0;
    mode    = '0;
    divider = '0;
    cycles(2);
    rst = 1'b0;

    // Square baseline: divider 4 gives tick every 4th edge, wave period 8.
    set_ch(0, 1'b1, 1'b0, 32'd4);
    cycles(20);

    // Pulse mode with divider 3; dividers 0 and 1 both tick every cycle.
    set_ch(1, 1'b1, 1'b1, 32'd3);
    set_ch(2, 1'b1, 1'b0, 32'd0);
    set_ch(3, 1'b1, 1'b0, 32'd1);
    cycles(12);
    mode[2] = 1'b1;
    cycles(4);

    // Divider change one edge into a period of 5: period still completes.
    set_ch(0, 1'b0, 1'b0, 32'd5);
    cycles(1);
    en[0] = 1'b1;
    cycles(1);
    divider[0 +: W] = 32'd2;
    cycles(12);

    // Enable dropped for 3 cycles mid-period, then restarted.
    divider[0 +: W] = 32'd4;
    cycles(6);
    en[0] = 1'b0;
    cycles(3);
    en[0] = 1'b1;
    cycles(10);

    // Two channels of divider 6 started 2 cycles apart, realigned by sync.
    set_ch(0, 1'b0, 1'b0, 32'd6);
    set_ch(1, 1'b0, 1'b0, 32'd6);
    cycles(1);
    en[0] = 1'b1;
    cycles(2);
    en[1] = 1'b1;
    cycles(5);
    sync = 1'b1;
    cycles(1);
    sync = 1'b0;
    cycles(20);

    // Reset at cnt=3 of a divider-8 period: no stale tick afterwards.
    set_ch(0, 1'b0, 1'b0, 32'd8);
    cycles(1);
    en[0] = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(12);

    // Largest divider: never reaches terminal in this window.
    set_ch(3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cycles(5);

    // Random traffic on small dividers, with occasional sync and reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, CH - 1);
        set_ch(ch, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               W'($urandom_range(0, 7)));
      end
      sync = ($urandom_range(0, 49) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cycles(1);
    end
    sync = 1'b0;
    rst  = 1'b0;
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_freq_multi.md
Name: gen_freq_multi

Overview:
- Parametrised, multi-channel successor to the single-channel frequency divider.
- Each of CHANNELS independent channels divides the system clock `clk` by a runtime divider and produces two outputs: a waveform (50%-duty square or one-cycle pulse, selectable per channel) and a registered one-cycle tick for use as a clock enable.
- Adds per-channel enable, glitch-free divider reload at period boundaries, and a global phase-sync input.
- Sits between the system clock and the timekeeping, display-multiplex and alarm-tone logic.

Parameters:
- WIDTH, 32, bit width of each divider and counter.
- CHANNELS, 4, number of independent divider channels.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  CHANNELS  per-channel enable; bit i enables channel i.
- mode  input  CHANNELS  per-channel waveform mode: 0 = square (toggle), 1 = pulse.
- divider  input  CHANNELS*WIDTH  packed dividers; channel i uses bits [i*WIDTH +: WIDTH].
- sync  input  1  global phase realign; restarts all channels at once.
- wave_out  output  CHANNELS  per-channel waveform.
- tick  output  CHANNELS  per-channel one-cycle terminal-count strobe.

Behaviour:
- Per-channel state: cnt[WIDTH], shadow divider div_q[WIDTH], wave_q, tick_q. All are registers; outputs come directly from registers, with no combinational path from inputs to outputs.
- Effective divider: D = (div_q == 0) ? 1 : div_q. A divider of 0 is legal and behaves exactly as 1.
- Terminal condition: cnt == D-1.
- Priority per clock edge: rst > sync > en low > normal count.
- rst:
  - cnt <= 0, wave_q <= 0, tick_q <= 0.
  - div_q <= current divider input.
  - All outputs read 0 in the cycle after the reset edge.
  - A reset mid-period discards the partial count; there is no tick for the aborted period.
- sync, applied to all channels regardless of en:
  - Same effect as rst: cnt 0, wave 0, tick 0, div_q reloaded.
  - Counting resumes on the next edge if en is high, so all enabled channels with equal D produce coincident ticks.
- en[i] low:
  - cnt 0, wave_q 0, tick_q 0.
  - div_q tracks the divider input every cycle.
- en[i] high, non-terminal: cnt <= cnt+1, tick_q <= 0.
- en[i] high, terminal:
  - cnt <= 0, tick_q <= 1.
  - div_q <= divider input. This is the only point at which a new divider takes effect while running, so a running period is never shortened or stretched.
  - mode 0: wave_q <= ~wave_q.
  - mode 1: wave_q <= 1 for this period.
- mode 1, non-terminal: wave_q <= 0. In mode 1, wave_out equals tick.
- Mode change while running: takes effect at the next edge. A square-to-pulse change may end a high phase early; this is accepted and no glitch filtering is required.
- Latency:
  - If en rises with cnt=0, tick is high in the cycle after the D-th enabled edge, then every D cycles.
  - Square-mode wave period is 2*D cycles at 50% duty.
  - With D=1: tick is held high continuously and wave toggles every cycle (period 2).
- Width and wrap:
  - cnt never exceeds D-1, so no overflow occurs. The maximum divider 2^WIDTH-1 is supported.
  - The D-1 comparison is computed from the clamped D and must not underflow.
- Channels are fully independent except for shared rst and sync. Simultaneous terminals on several channels are all honoured.

Test Plan:
- Square baseline: rst 2 cycles; ch0 divider=4, mode=0, en=1 → tick0 high every 4th cycle (first on the 4th edge after enable); wave_out0 period 8, high 4 / low 4.
- Pulse and divider edge cases: ch1 mode=1, divider=3 → wave_out1 == tick1, high 1 of every 3 cycles. ch2 divider=0 and ch3 divider=1 → tick held high continuously; in mode 0, wave toggles every cycle.
- Divider change mid-period: ch0 running with divider=5; set divider=2 at cnt=1 → current period still completes at 5 cycles, subsequent ticks every 2 cycles; no intermediate tick.
- Enable and sync: toggle en0 low for 3 cycles mid-period → wave0=0 and tick0=0 while low; first tick 4 cycles after re-enable (divider=4). Then, with ch0 divider=6 and ch1 divider=6 started 2 cycles apart, pulse sync → ticks coincide from then on.
- Reset mid-operation: assert rst for 1 cycle at cnt=3 of divider=8 → all wave/tick 0 the next cycle; first post-reset tick exactly 8 enabled cycles later; no stale tick emitted.
